// File: rtl/registro_pipeline.sv
// registro_pipeline: elastic pipeline register with per-stage valids, bubble collapsing and flush.
// Define REGISTRO_PIPELINE_OCC_EN to add the registered occupancy counter output OCC.
module registro_pipeline #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] DATAIN,
  input  logic             VALID_IN,
  output logic             READY_IN,
  output logic [WIDTH-1:0] DATAOUT,
  output logic             VALID_OUT,
  input  logic             READY_OUT,
  input  logic             FLUSH
`ifdef REGISTRO_PIPELINE_OCC_EN
  ,output logic [$clog2(STAGES+1)-1:0] OCC
`endif
);
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [STAGES-1:0] v_q, v_d, rdy;
  // A stage can load when it is empty or everything ahead of it can move.
  always_comb begin
    logic r;
    r = READY_OUT;
    rdy = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      r = !v_q[i] || r;
      rdy[i] = r;
    end
  end
  always_comb begin
    data_d = data_q;
    v_d = v_q;
    if (FLUSH) begin
      v_d = '0;
    end else begin
      if (rdy[0]) begin
        data_d[0] = DATAIN;
        v_d[0] = VALID_IN;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (rdy[i]) begin
          data_d[i] = data_q[i-1];
          v_d[i] = v_q[i-1];
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      data_q <= '{default: '0};
    end else begin
      v_q <= v_d;
      data_q <= data_d;
    end
  end
  assign READY_IN  = rdy[0] && !FLUSH;
  assign VALID_OUT = v_q[STAGES-1] && !FLUSH;
  assign DATAOUT   = data_q[STAGES-1];
`ifdef REGISTRO_PIPELINE_OCC_EN
  localparam int OW = $clog2(STAGES + 1);
  logic [OW-1:0] occ_q, occ_d;
  assign occ_d = FLUSH ? '0 : occ_q + OW'(VALID_IN && READY_IN) - OW'(VALID_OUT && READY_OUT);
  always_ff @(posedge clk) begin
    occ_q <= !rst_n ? '0 : occ_d;
  end
  assign OCC = occ_q;
`endif
endmodule

// File: doc/registro_pipeline.md
# registro_pipeline

Parametrised pipeline register: a chain of `STAGES` registers of `WIDTH` bits with per-stage valid bits, a valid/ready handshake on both sides, and bubble collapsing. It replaces fixed-width single registers wherever data must be delayed, retimed or buffered under downstream backpressure. It also adds a synchronous flush.

## Interface
- `WIDTH`, 8, data width in bits (≥1)
- `STAGES`, 3, number of register stages (≥1)

- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `DATAIN`  in  WIDTH  input data
- `VALID_IN`  in  1  `DATAIN` is valid this cycle
- `READY_IN`  out  1  pipeline accepts `DATAIN` this cycle
- `DATAOUT`  out  WIDTH  output data (last stage register)
- `VALID_OUT`  out  1  `DATAOUT` is valid
- `READY_OUT`  in  1  downstream accepts `DATAOUT`
- `FLUSH`  in  1  discard all pipeline contents
- `OCC`  out  $clog2(STAGES+1)  number of valid stages (only with `REGISTRO_PIPELINE_OCC_EN`)

## Operation
- State: `data[i]` (WIDTH bits) and `v[i]` for i = 0..STAGES-1. Stage 0 is the input side; stage STAGES-1 drives `DATAOUT`.
- Per-stage readiness:
  - `rdy[STAGES-1] = !v[STAGES-1] || READY_OUT`
  - `rdy[i] = !v[i] || rdy[i+1]`
  - `READY_IN = rdy[0] && !FLUSH`
- Stage i loads at the clock edge when `rdy[i]` is 1 and FLUSH is 0:
  - i=0: `data[0] <= DATAIN`, `v[0] <= VALID_IN`
  - i>0: `data[i] <= data[i-1]`, `v[i] <= v[i-1]`
- A stage with `rdy[i]` = 0 holds its data and valid bit.
- Bubble collapsing: an empty stage always accepts the stage before it, so gaps close while the output is stalled.
- Transfers:
  - Input transfer = `VALID_IN && READY_IN`.
  - Output transfer = `VALID_OUT && READY_OUT`.
  - Data order is preserved. No item is duplicated or dropped, except by FLUSH.
- `DATAOUT = data[STAGES-1]`.
- `VALID_OUT = v[STAGES-1] && !FLUSH`.
- Data registers load only when their stage loads. Bit-width is preserved end to end; there is no arithmetic.
- FLUSH = 1 at an edge:
  - all `v[i] <= 0`; data registers are unchanged
  - `DATAIN` offered that cycle is not accepted
  - the item at the output is not transferred
- Reset (`rst_n` = 0 at an edge):
  - all `v[i]` and `data[i]` go to 0, so `VALID_OUT` = 0, `DATAOUT` = 0, `OCC` = 0
  - `READY_IN` = 1 after reset
  - reset overrides FLUSH and any transfer in flight
- STAGES = 1: a single-entry buffer; `READY_IN = !v[0] || READY_OUT`.

## Timing
- Latency: an item accepted at edge k appears at `VALID_OUT`/`DATAOUT` after edge k+STAGES-1 when the pipeline is unstalled. The output is registered.
- Throughput: 1 item/cycle while `READY_OUT` = 1.
- `READY_IN` is combinational from `READY_OUT`, `FLUSH` and the valid bits through a STAGES-deep ready chain. There is no combinational path from `VALID_IN` or `DATAIN` to any output.
- Full pipeline with `READY_OUT` = 1: an input and an output transfer occur in the same cycle, and occupancy is unchanged.
- Full pipeline with `READY_OUT` = 0: `READY_IN` = 0 until an output transfer or FLUSH.

## Configuration
- `REGISTRO_PIPELINE_OCC_EN` defined:
  - port `OCC` exists and is registered
  - `OCC` = popcount of `v` after each edge: +1 on an input-only transfer, −1 on an output-only transfer, unchanged when both or neither occur
  - `OCC` goes to 0 on FLUSH and on reset
- Not defined: port `OCC` and its counter are absent; all other behaviour is identical.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with `VALID_IN` = 1 and `DATAIN` = 8'hFF. Required: `VALID_OUT` = 0, `DATAOUT` = 0, `READY_IN` = 1 (and `OCC` = 0 when enabled).
- Streaming (WIDTH=8, STAGES=3): send 0x01..0x0A back-to-back with `READY_OUT` = 1. Required: 0x01 appears 2 cycles after acceptance, then one item per cycle in order, with no gaps.
- Stall and collapse: send 0x11, then a 1-cycle bubble, then 0x22 and 0x33, with `READY_OUT` = 0. Required:
  - `READY_IN` falls after 3 items are held and `OCC` = 3
  - after `READY_OUT` = 1, the output order is 0x11, 0x22, 0x33 on consecutive cycles
- Full with simultaneous in/out: fill 3 items, then `READY_OUT` = 1 and `VALID_IN` = 1 with 0x44. Required: `READY_IN` = 1, 0x44 accepted, the oldest item leaves, `OCC` stays 3.
- Flush: with 2 items held and `READY_OUT` = 0, pulse `FLUSH` for 1 cycle with `VALID_IN` = 1. Required:
  - `READY_IN` = 0 and `VALID_OUT` = 0 during the pulse
  - all stages empty after the edge; the next item accepted is the first one seen at the output
- STAGES=1: alternate `READY_OUT` 1/0 with continuous input 0xA0, 0xA1, ... Required: no loss and no duplication; `READY_IN` mirrors `!v[0] || READY_OUT`.
